// File: rtl/dm_sized.sv
// Parametrised byte-lane data memory with a registered one-cycle response,
// alignment-fault reporting and an optional zero-fill sequence after reset.
module dm_sized #(
   parameter int ADDR_W         = 12,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              uns,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              ready,
   output logic              rvalid,
   output logic [31:0]       rdata,
   output logic              fault
);
   localparam int IW    = ADDR_W - 2;
   localparam int DEPTH = 1 << IW;

   typedef enum logic {CLEAR, IDLE} state_t;

   state_t        state, state_nxt;
   logic [IW-1:0] clr_ptr;
   logic [31:0]   mem [DEPTH];

   logic          accept, misalign;
   logic [IW-1:0] widx;
   logic [31:0]   word, bsh, hsh, ld_res, wword, bmask;
   logic          rvalid_q, fault_q;
   logic [31:0]   rdata_q;

   assign ready  = (state == IDLE);
   assign accept = req & ready & ~rst;
   assign widx   = addr[ADDR_W-1:2];
   assign word   = mem[widx];

   // Lane selection by shifting the selected lane down to bit 0.
   assign bsh = word >> {addr[1:0], 3'b000};
   assign hsh = word >> {addr[1], 4'b0000};

   always_comb begin
      misalign = 1'b0;
      ld_res   = word;
      wword    = wdata;
      bmask    = 32'hFFFF_FFFF;
      case (size)
         2'd0: begin
            ld_res = uns ? {24'h0, bsh[7:0]} : {{24{bsh[7]}}, bsh[7:0]};
            wword  = {4{wdata[7:0]}};
            bmask  = 32'h0000_00FF << {addr[1:0], 3'b000};
         end
         2'd1: begin
            misalign = addr[0];
            ld_res   = uns ? {16'h0, hsh[15:0]} : {{16{hsh[15]}}, hsh[15:0]};
            wword    = {2{wdata[15:0]}};
            bmask    = 32'h0000_FFFF << {addr[1], 4'b0000};
         end
         2'd2: misalign = |addr[1:0];
         default: misalign = 1'b1;
      endcase
   end

   always_comb begin
      state_nxt = state;
      if (state == CLEAR && (&clr_ptr))
         state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR_ON_RESET ? CLEAR : IDLE;
         clr_ptr <= '0;
      end else begin
         state <= state_nxt;
         if (state == CLEAR)
            clr_ptr <= clr_ptr + IW'(1);
      end
   end

   // Sub-word stores merge into the current word so untouched lanes survive.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == CLEAR)
            mem[clr_ptr] <= '0;
         else if (accept && we && !misalign)
            mem[widx] <= (word & ~bmask) | (wword & bmask);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid_q <= 1'b0;
         fault_q  <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= accept;
         fault_q  <= accept & misalign;
         rdata_q  <= (accept && !we && !misalign) ? ld_res : 32'h0;
      end
   end

   // A response still in flight when reset arrives must not be seen.
   assign rvalid = rvalid_q & ~rst;
   assign fault  = fault_q & ~rst;
   assign rdata  = rdata_q & {32{~rst}};

endmodule

// File: tb/tb_dm_sized.sv
// Directed bench for dm_sized (ADDR_W=6) with a byte-array reference model;
// a second instance with CLEAR_ON_RESET=0 shares the stimulus.
module tb_dm_sized;
   logic        clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0, uns = 1'b0;
   logic [1:0]  size = 2'd0;
   logic [5:0]  addr = 6'd0;
   logic [31:0] wdata = 32'd0;
   logic        ready, rvalid, fault;
   logic [31:0] rdata;
   logic        n_ready, n_rvalid, n_fault;
   logic [31:0] n_rdata;
   int nvec = 0, nbad = 0;

   always #5 clk = ~clk;

   dm_sized #(.ADDR_W(6), .CLEAR_ON_RESET(1'b1)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .uns(uns),
      .addr(addr), .wdata(wdata), .ready(ready), .rvalid(rvalid),
      .rdata(rdata), .fault(fault));

   dm_sized #(.ADDR_W(6), .CLEAR_ON_RESET(1'b0)) dut_nc (
      .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .uns(uns),
      .addr(addr), .wdata(wdata), .ready(n_ready), .rvalid(n_rvalid),
      .rdata(n_rdata), .fault(n_fault));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model of the clear-on-reset instance: byte array + clear countdown.
   logic        started = 1'b0;
   int          clr_left = 0;
   logic [7:0]  mm [64];
   logic        ev = 1'b0, ef = 1'b0;
   logic [31:0] ed = 32'h0;
   int          nb;
   logic        bad, acc;
   logic [31:0] v;

   always @(posedge clk) begin
      if (rst) begin
         started  = 1'b1;
         clr_left = 16;
         for (int i = 0; i < 64; i++) mm[i] = 8'h00;
         ev = 1'b0; ef = 1'b0; ed = 32'h0;
      end else begin
         acc = req && started && (clr_left == 0);
         if (clr_left > 0) clr_left--;
         ev = 1'b0; ef = 1'b0; ed = 32'h0;
         if (acc) begin
            nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
            bad = (size == 2'd3) || ((int'(addr) % nb) != 0);
            ev  = 1'b1;
            if (bad) ef = 1'b1;
            else if (we) begin
               for (int i = 0; i < nb; i++) mm[int'(addr) + i] = wdata[8*i +: 8];
            end else begin
               v = 32'h0;
               for (int i = 0; i < nb; i++) v = v | (32'(mm[int'(addr) + i]) << (8*i));
               if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
               ed = v;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("ready",  32'(ready),  32'(clr_left == 0));
         chk("rvalid", 32'(rvalid), rst ? 32'h0 : 32'(ev));
         chk("fault",  32'(fault),  rst ? 32'h0 : 32'(ef));
         chk("rdata",  rdata,       rst ? 32'h0 : ed);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic op(input logic w, input logic [1:0] s, input logic u,
                     input logic [5:0] a, input logic [31:0] d);
      req = 1'b1; we = w; size = s; uns = u; addr = a; wdata = d;
      cyc();
      req = 1'b0; we = 1'b0;
   endtask

   task automatic ld_chk(input string nm, input logic [1:0] s, input logic u,
                         input logic [5:0] a, input logic [31:0] exp);
      op(1'b0, s, u, a, 32'h0);
      chk({nm, "_v"}, 32'(rvalid), 32'h1);
      chk({nm, "_f"}, 32'(fault), 32'h0);
      chk(nm, rdata, exp);
      chk({nm, "_model"}, ed, exp);
   endtask

   task automatic flt_chk(input string nm, input logic w, input logic [1:0] s,
                          input logic [5:0] a);
      op(w, s, 1'b0, a, 32'hFFFF_FFFF);
      chk({nm, "_v"}, 32'(rvalid), 32'h1);
      chk({nm, "_f"}, 32'(fault), 32'h1);
      chk({nm, "_d"}, rdata, 32'h0);
   endtask

   task automatic clear_wait(input string nm);
      for (int k = 0; k < 16; k++) begin
         chk({nm, "_busy"}, 32'(ready), 32'h0);
         cyc();
      end
      chk({nm, "_done"}, 32'(ready), 32'h1);
   endtask

   initial begin
      rst = 1'b1;
      cyc(); cyc();
      rst = 1'b0;
      chk("nc_ready_now", 32'(n_ready), 32'h1);
      clear_wait("clr1");

      op(1'b1, 2'd2, 1'b0, 6'h3C, 32'hDEAD_BEEF);
      chk("st3c_v", 32'(rvalid), 32'h1);
      ld_chk("ld3c_pre", 2'd2, 1'b0, 6'h3C, 32'hDEAD_BEEF);

      // Reset again, then re-reset at edge 8 of the clear.
      rst = 1'b1; cyc(); rst = 1'b0;
      repeat (8) cyc();
      rst = 1'b1; cyc(); rst = 1'b0;
      clear_wait("clr2");
      ld_chk("ld3c_clr", 2'd2, 1'b0, 6'h3C, 32'h0);

      op(1'b1, 2'd0, 1'b0, 6'h05, 32'hFFFF_FF80);
      chk("sb_v", 32'(rvalid), 32'h1);
      chk("sb_d", rdata, 32'h0);
      ld_chk("lb_s", 2'd0, 1'b0, 6'h05, 32'hFFFF_FF80);
      ld_chk("lb_u", 2'd0, 1'b1, 6'h05, 32'h0000_0080);
      ld_chk("lw_04", 2'd2, 1'b0, 6'h04, 32'h0000_8000);

      op(1'b1, 2'd2, 1'b0, 6'h10, 32'h1122_3344);
      op(1'b1, 2'd1, 1'b0, 6'h12, 32'h1234_BEEF);
      ld_chk("lw_10", 2'd2, 1'b0, 6'h10, 32'hBEEF_3344);
      ld_chk("lh_s", 2'd1, 1'b0, 6'h12, 32'hFFFF_BEEF);
      ld_chk("lh_u", 2'd1, 1'b1, 6'h10, 32'h0000_3344);
      ld_chk("lb_13", 2'd0, 1'b1, 6'h13, 32'h0000_00BE);
      ld_chk("lw_uns", 2'd2, 1'b1, 6'h10, 32'hBEEF_3344);

      flt_chk("sw_mis", 1'b1, 2'd2, 6'h11);
      ld_chk("lw_10b", 2'd2, 1'b0, 6'h10, 32'hBEEF_3344);
      flt_chk("lh_mis", 1'b0, 2'd1, 6'h13);
      flt_chk("sz3_ld", 1'b0, 2'd3, 6'h00);
      flt_chk("sz3_st", 1'b1, 2'd3, 6'h00);
      ld_chk("lw_00", 2'd2, 1'b0, 6'h00, 32'h0);
      cyc();
      chk("idle_v", 32'(rvalid), 32'h0);
      chk("idle_d", rdata, 32'h0);

      op(1'b1, 2'd2, 1'b0, 6'h20, 32'hCAFE_F00D);
      chk("b2b_st_v", 32'(rvalid), 32'h1);
      chk("b2b_st_d", rdata, 32'h0);
      ld_chk("b2b_ld", 2'd2, 1'b0, 6'h20, 32'hCAFE_F00D);

      // Load accepted, then reset next cycle with a store riding on it.
      req = 1'b1; we = 1'b0; size = 2'd2; addr = 6'h20;
      cyc();
      rst = 1'b1; we = 1'b1; wdata = 32'h1234_5678;
      #1;
      chk("rst_sup_v", 32'(rvalid), 32'h0);
      chk("nc_rst_sup_v", 32'(n_rvalid), 32'h0);
      cyc();
      rst = 1'b0; req = 1'b0; we = 1'b0;
      chk("nc_ready_rst", 32'(n_ready), 32'h1);
      chk("ready_rst", 32'(ready), 32'h0);
      op(1'b0, 2'd2, 1'b0, 6'h20, 32'h0);
      chk("nc_keep_v", 32'(n_rvalid), 32'h1);
      chk("nc_keep_d", n_rdata, 32'hCAFE_F00D);
      chk("clr_noresp", 32'(rvalid), 32'h0);
      repeat (16) cyc();
      chk("clr3_done", 32'(ready), 32'h1);
      ld_chk("ld20_clr", 2'd2, 1'b0, 6'h20, 32'h0);
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end
endmodule
